addsub_seq_ctrl: RTL

Nibble-serial add/subtract sequencer. It accepts WIDTH-bit operands and an add/sub select over a valid/ready handshake. It then steps a single internal 4-bit add/sub slice across the operands, one nibble per cycle, least-significant nibble first, chaining the carry between nibbles. It returns the result with carry, signed-overflow and zero flags over a second valid/ready handshake, so one 4-bit slice can serve wide arithmetic in area-constrained datapaths.

---
 rtl/addsub_seq_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: nibble-serial add/subtract sequencer.
// A single 4-bit add/sub slice is stepped across WIDTH-bit operands, one
// nibble per cycle and least-significant first, with a registered carry
// chain. Operands arrive over a valid/ready handshake. Results and flags
// leave over a second valid/ready handshake.
module addsub_seq_ctrl #(
   parameter  int NIBBLES = 4,
   localparam int WIDTH   = 4 * NIBBLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_r, b_r;
   logic             sub_r;
   logic             carry;
   logic [IDXW-1:0]  idx;
   logic [IDXW+1:0]  nib_base;
   logic             accept;
   logic             last;

   logic [3:0]       a_nib, b_nib;
   logic [4:0]       slice_sum;
   logic [3:0]       low_sum;
   logic             c_next;
   logic             c_msb;
   logic [WIDTH-1:0] result_nxt;

   assign nib_base = {idx, 2'b00};
   assign last     = (idx == LAST_IDX);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every clocked block uses non-blocking assignments so all
      // registers update together from pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state, handshake outputs and the accept strobe.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         RUN:  if (last) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      accept = in_valid && in_ready;
      if (accept) state_nxt = RUN;
   end

   // The shared 4-bit slice. The carry register already holds sub_r on
   // nibble 0, so it serves as the carry-in on every nibble.
   always_comb begin
      a_nib      = a_r[nib_base +: 4];
      b_nib      = b_r[nib_base +: 4] ^ {4{sub_r}};
      slice_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
      low_sum    = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry};
      c_next     = slice_sum[4];
      c_msb      = low_sum[3];
      result_nxt = result;
      result_nxt[nib_base +: 4] = slice_sum[3:0];
   end

   // Operand capture on accept, then one nibble per RUN cycle. The flags
   // are resolved on the last nibble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         sub_r  <= 1'b0;
         carry  <= 1'b0;
         idx    <= '0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else if (accept) begin
         a_r   <= a;
         b_r   <= b;
         sub_r <= sub;
         carry <= sub;
         idx   <= '0;
      end else if (state == RUN) begin
         result <= result_nxt;
         carry  <= c_next;
         if (last) begin
            cout <= c_next;
            ovf  <= c_msb ^ c_next;
            zero <= (result_nxt == '0);
            idx  <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule
